au_signapply_seq: RTL and testbench
===================================

AU_SIGNAPPLY_SEQ -- requirements
Module: au_signapply_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word length of magnitude and result (legal 2..64).
REQ-002 The block SHALL have parameter DIGIT, default 2, giving bits processed per cycle; WIDTH SHALL be a multiple of DIGIT.
REQ-003 The block SHALL have one clock, port clk, input, 1 bit; all state changes on its rising edge.
REQ-004 The block SHALL have reset port rst_n, input, 1 bit, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit, asserted when an operand is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, asserted when an operand can be accepted.
REQ-007 The block SHALL have port sgn, input, 1 bit, the sign to apply (1 = negative).
REQ-008 The block SHALL have port mag, input, WIDTH bits, an unsigned magnitude.
REQ-009 The block SHALL have port out_valid, output, 1 bit, asserted while a result is held.
REQ-010 The block SHALL have port out_ready, input, 1 bit, asserted when the consumer takes the result.
REQ-011 The block SHALL have port z, output, WIDTH bits, the two's-complement result.
REQ-012 The block SHALL have port ovf, output, 1 bit, present only when the macro in REQ-028 is defined.

Function
REQ-013 The result SHALL be z = mag when sgn=0, and z = (~mag + 1) mod 2^WIDTH when sgn=1; this is the inverse of the absolute-value unit.
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; reset enters IDLE.
REQ-015 In IDLE, in_ready SHALL be 1; the cycle in which in_valid=1 holds, sgn and mag SHALL be captured and the FSM SHALL move to BUSY.
REQ-016 In BUSY, the block SHALL process one DIGIT-bit slice per cycle, LSB first, for WIDTH/DIGIT cycles.
REQ-017 Each slice SHALL be computed as (sgn ? ~slice : slice) + carry, with the carry register initialised to sgn at capture.
REQ-018 After the last slice, the FSM SHALL move to DONE; out_valid SHALL rise exactly WIDTH/DIGIT cycles after the accepting edge.
REQ-019 In DONE, z (and ovf) SHALL stay stable until out_valid and out_ready are both 1; on that edge the FSM SHALL return to IDLE.
REQ-020 in_ready SHALL be 0 in BUSY and DONE; in_valid SHALL be ignored there, with no queueing.
REQ-021 The block SHALL accept a new operand no earlier than the cycle after the output handshake, so throughput is one result per WIDTH/DIGIT+2 cycles.
REQ-022 sgn=1 with mag=0 SHALL produce z=0; negative zero is normalised.
REQ-023 z SHALL be driven from a register, with no combinational path from inputs to outputs.

Reset
REQ-024 Asserting rst_n low SHALL immediately force in_ready=0, out_valid=0, z=0, ovf=0 and the state to IDLE.
REQ-025 Reset asserted mid-BUSY or mid-DONE SHALL discard the operation; no result SHALL be emitted after release.
REQ-026 in_ready SHALL become 1 in the first cycle after rst_n is released.
REQ-027 The capture, slice and carry registers SHALL be cleared to 0 by reset.

Configuration
REQ-028 Macro AU_SIGNAPPLY_OVF_EN SHALL control overflow detection and saturation.
REQ-029 With AU_SIGNAPPLY_OVF_EN defined, ovf SHALL be 1 when sgn=0 and mag >= 2^(WIDTH-1), or when sgn=1 and mag > 2^(WIDTH-1).
REQ-030 With AU_SIGNAPPLY_OVF_EN defined and ovf=1, z SHALL saturate to 2^(WIDTH-1)-1 for sgn=0 and to 2^(WIDTH-1) for sgn=1.
REQ-031 Without AU_SIGNAPPLY_OVF_EN, the ovf port SHALL be absent and z SHALL always wrap per REQ-013.
REQ-032 Latency SHALL be identical whether or not AU_SIGNAPPLY_OVF_EN is defined.

Verification (WIDTH=8, DIGIT=2)
REQ-033 Apply sgn=1, mag=0x05, out_ready=1 -> out_valid rises 4 cycles after accept with z=0xFB, then in_ready returns next cycle.
REQ-034 Apply sgn=1, mag=0x00 -> z=0x00; apply sgn=0, mag=0x7F -> z=0x7F; apply sgn=1, mag=0x80 -> z=0x80 with ovf=0.
REQ-035 Apply sgn=0, mag=0xC8 -> with macro z=0x7F and ovf=1; without macro z=0xC8.
REQ-036 Hold out_ready=0 for 10 cycles after out_valid -> z stable and in_ready=0 throughout, and a toggling in_valid is ignored.
REQ-037 Pulse rst_n low in the 2nd BUSY cycle -> out_valid stays 0, then in_ready=1 the cycle after release.
REQ-038 Exhaustive sweep over all 512 (sgn, mag) pairs with random out_ready stalls -> every z matches REQ-013, REQ-030 and REQ-031, with zero mismatches reported.

Source files
------------

// File: rtl/au_signapply_seq.sv
// Sequential sign-apply unit: z = sgn ? -mag : mag, computed DIGIT bits per cycle, LSB first.
// Optional overflow detect/saturate enabled by macro AU_SIGNAPPLY_OVF_EN (adds port ovf).
module au_signapply_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sgn,
  input  logic [WIDTH-1:0] mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z
`ifdef AU_SIGNAPPLY_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NSLICE = WIDTH / DIGIT;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             sgn_r;
  logic             carry;
  logic [WIDTH-1:0] mag_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [DIGIT-1:0] slice;
  logic [DIGIT:0]   sum;
  logic             last;

`ifdef AU_SIGNAPPLY_OVF_EN
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  logic ovf_pend;
`endif

  // Gated by rst_n so in_ready drops the instant reset asserts.
  assign in_ready  = (state == IDLE) & rst_n;
  assign out_valid = (state == DONE);

  // mag_r shifts right each slice; the result enters acc from the top,
  // so after NSLICE slices acc holds the full word in place.
  always_comb begin
    slice   = mag_r[DIGIT-1:0];
    sum     = {1'b0, (sgn_r ? ~slice : slice)} + {{DIGIT{1'b0}}, carry};
    acc_nxt = acc >> DIGIT;
    acc_nxt[WIDTH-1 -: DIGIT] = sum[DIGIT-1:0];
    last    = (state == BUSY) && (cnt == CW'(NSLICE - 1));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_r    <= 1'b0;
      carry    <= 1'b0;
      mag_r    <= '0;
      acc      <= '0;
      cnt      <= '0;
      z        <= '0;
`ifdef AU_SIGNAPPLY_OVF_EN
      ovf_pend <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      if (state == IDLE && in_valid) begin
        sgn_r <= sgn;
        carry <= sgn;
        mag_r <= mag;
        acc   <= '0;
        cnt   <= '0;
`ifdef AU_SIGNAPPLY_OVF_EN
        ovf_pend <= sgn ? (mag > MSB_ONLY) : mag[WIDTH-1];
`endif
      end else if (state == BUSY) begin
        mag_r <= mag_r >> DIGIT;
        acc   <= acc_nxt;
        carry <= sum[DIGIT];
        cnt   <= cnt + CW'(1);
        if (last) begin
`ifdef AU_SIGNAPPLY_OVF_EN
          ovf <= ovf_pend;
          if (ovf_pend)
            z <= sgn_r ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          else
            z <= acc_nxt;
`else
          z <= acc_nxt;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_au_signapply_seq.sv
// Self-checking bench for au_signapply_seq (WIDTH=8, DIGIT=2) against an arithmetic reference model.
module tb_au_signapply_seq;

  localparam int unsigned W = 8;
  localparam int unsigned D = 2;
  localparam int          N = W / D;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         sgn;
  logic [W-1:0] mag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  au_signapply_seq #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sgn       (sgn),
    .mag       (mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
`ifdef AU_SIGNAPPLY_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef AU_SIGNAPPLY_OVF_EN
  assign ovf = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: two's-complement negation by arithmetic, then optional saturation.
  function automatic logic [W-1:0] ref_z(input bit s, input int unsigned m);
    longint full, half, v;
    full = longint'(1) << W;
    half = longint'(1) << (W - 1);
    v    = s ? (full - longint'(m)) % full : longint'(m);
`ifdef AU_SIGNAPPLY_OVF_EN
    if (!s && longint'(m) >= half) v = half - 1;
    if (s && longint'(m) > half)   v = half;
`endif
    return v[W-1:0];
  endfunction

  function automatic bit ref_ovf(input bit s, input int unsigned m);
    longint half;
    half = longint'(1) << (W - 1);
`ifdef AU_SIGNAPPLY_OVF_EN
    return s ? (longint'(m) > half) : (longint'(m) >= half);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operand through; returns observations for the caller to check.
  task automatic run_op(input bit s, input logic [W-1:0] m, input int stall,
                        output int lat, output logic [W-1:0] zo, output logic ovo,
                        output bit stable, output logic ir_after, output logic ov_after,
                        output int acc_cyc);
    int n;
    n = 0;
    lat = -1; zo = 'x; ovo = 1'bx; stable = 1'b0; ir_after = 1'bx; ov_after = 1'bx; acc_cyc = -1;
    while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (in_ready !== 1'b1) return;
    in_valid = 1'b1; sgn = s; mag = m; out_ready = 1'b0;
    acc_cyc = cyc;
    tick();
    sgn = 1'($urandom); mag = W'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      in_valid = 1'($urandom);
      tick();
      lat++;
    end
    zo = z; ovo = ovf;
    stable = 1'b1;
    repeat (stall) begin
      in_valid = 1'($urandom);
      tick();
      if (z !== zo || ovf !== ovo || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ir_after = in_ready; ov_after = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || z !== '0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b z=%h ovf=%b, want 0 0 00 0", in_ready, out_valid, z, ovf);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat, ac; logic [W-1:0] zo; logic ovo, ir, ov; bit st;
    run_op(1'b1, 8'h05, 0, lat, zo, ovo, st, ir, ov, ac);
    n_checks++;
    if (lat !== N) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, N); end
    n_checks++;
    if (zo !== 8'hFB) begin n_fail++; $display("FAIL basic_z: got %h want fb", zo); end
    n_checks++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      n_fail++; $display("FAIL basic_handshake: in_ready=%b out_valid=%b want 1 0", ir, ov);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0] mags [7] = '{8'h00, 8'h7F, 8'h80, 8'hC8, 8'h81, 8'h80, 8'hFF};
    bit           sgns [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      int lat, ac; logic [W-1:0] zo, exp_z; logic ovo, ir, ov; bit st;
      run_op(sgns[i], mags[i], 1, lat, zo, ovo, st, ir, ov, ac);
      exp_z = ref_z(sgns[i], int'(mags[i]));
      n_checks++;
      if (zo !== exp_z) begin
        n_fail++; $display("FAIL corner_z s=%0d mag=%h: got %h want %h", sgns[i], mags[i], zo, exp_z);
      end
`ifdef AU_SIGNAPPLY_OVF_EN
      n_checks++;
      if (ovo !== ref_ovf(sgns[i], int'(mags[i]))) begin
        n_fail++; $display("FAIL corner_ovf s=%0d mag=%h: got %b want %b", sgns[i], mags[i], ovo, ref_ovf(sgns[i], int'(mags[i])));
      end
`endif
    end
  endtask

  task automatic test_stall();
    int lat, ac; logic [W-1:0] zo; logic ovo, ir, ov; bit st;
    run_op(1'b1, 8'h3C, 10, lat, zo, ovo, st, ir, ov, ac);
    n_checks++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL stall_stable: got %b want 1", st); end
    n_checks++;
    if (zo !== 8'hC4) begin n_fail++; $display("FAIL stall_z: got %h want c4", zo); end
    n_checks++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      n_fail++; $display("FAIL stall_handshake: in_ready=%b out_valid=%b want 1 0", ir, ov);
    end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    in_valid = 1'b1; sgn = 1'b1; mag = 8'h11; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || z !== '0) begin
      n_fail++; $display("FAIL midreset_state: out_valid=%b in_ready=%b z=%h want 0 0 00", out_valid, in_ready, z);
    end
    #3 rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: in_ready=%b want 1", in_ready); end
    quiet = 1'b1;
    repeat (N + 3) begin
      tick();
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1) begin n_fail++; $display("FAIL midreset_no_result: got %b want 1", quiet); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, ac1, ac2; logic [W-1:0] z1, z2; logic o1, o2, ir, ov; bit st;
    run_op(1'b0, 8'h12, 0, lat1, z1, o1, st, ir, ov, ac1);
    run_op(1'b1, 8'h01, 0, lat2, z2, o2, st, ir, ov, ac2);
    n_checks++;
    if (ac2 - ac1 !== N + 2) begin
      n_fail++; $display("FAIL b2b_period: got %0d want %0d", ac2 - ac1, N + 2);
    end
    n_checks++;
    if (z1 !== 8'h12 || z2 !== 8'hFF) begin
      n_fail++; $display("FAIL b2b_z: got %h %h want 12 ff", z1, z2);
    end
  endtask

  task automatic test_sweep();
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 256; m++) begin
        int lat, ac; logic [W-1:0] zo, exp_z; logic ovo, ir, ov; bit st;
        run_op(1'(s), W'(m), int'($urandom_range(0, 3)), lat, zo, ovo, st, ir, ov, ac);
        exp_z = ref_z(1'(s), m);
        n_checks++;
        if (zo !== exp_z || lat !== N) begin
          n_fail++; $display("FAIL sweep s=%0d mag=%h: z=%h lat=%0d want z=%h lat=%0d", s, m, zo, lat, exp_z, N);
        end
`ifdef AU_SIGNAPPLY_OVF_EN
        n_checks++;
        if (ovo !== ref_ovf(1'(s), m)) begin
          n_fail++; $display("FAIL sweep_ovf s=%0d mag=%h: got %b want %b", s, m, ovo, ref_ovf(1'(s), m));
        end
`endif
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; sgn = 1'b0; mag = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
